// File: rtl/fpmul_arb.sv
// Round-robin arbiter and sequencer sharing one combinational FP multiplier
// among NREQ requesters. One transaction at a time: accept, execute, respond.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grant is combinational from req_valid
// EXEC  | latched operands drive the multiplier; product captured
// RESP  | product presented to the owner until rsp_ready[owner]
module fpmul_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_s,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]    op_a_q, op_a_d;
    logic [31:0]    op_b_q, op_b_d;
    logic [31:0]    res_q, res_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    logic [IDW-1:0] owner_inc;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        owner_inc = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + 1'b1;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        rsp_id_d = rsp_id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d  = req_a[{grant_idx, 5'b0} +: 32];
                    op_b_d  = req_b[{grant_idx, 5'b0} +: 32];
                    owner_d = grant_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // rsp_id is loaded together with the product so both hold
                // their previous values until the response phase begins.
                res_d    = mul_s;
                rsp_id_d = owner_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rr_ptr_d = owner_inc;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            rsp_id_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            rsp_id_q <= rsp_id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
        end
    end

    // One-hot handshake outputs; req_ready is suppressed while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && (state_q == IDLE) && grant_found && (grant_idx == IDW'(i));
            rsp_valid[i] = (state_q == RESP) && (owner_q == IDW'(i));
        end
    end

    assign rsp_data = res_q;
    assign rsp_id   = rsp_id_q;
    assign mul_a    = op_a_q;
    assign mul_b    = op_b_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fpmul_arb.sv
// Bench for fpmul_arb: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fpmul_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic [31:0]         mul_s;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;
    int grants[$];

    fpmul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_s     (mul_s),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple truncating FP multiply for normal operands; zero in gives signed zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    assign mul_s = fmul(mul_a, mul_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Transaction-level model: at most one transaction in flight, aged in cycles since accept.
    bit          m_have;
    int          m_age;
    int          m_owner;
    int          m_ptr;
    logic [31:0] m_mul_a, m_mul_b, m_last_data;
    int          m_last_id;
    int          m_pick;
    logic [31:0] e_ready, e_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_have = 0; m_age = 0; m_owner = 0; m_ptr = 0;
            m_mul_a = '0; m_mul_b = '0; m_last_data = '0; m_last_id = 0;
        end
        m_pick  = rr_pick(req_valid, m_ptr);
        e_ready = (rst_n && !m_have && m_pick >= 0) ? (32'd1 << m_pick) : 32'd0;
        e_valid = (m_have && m_age >= 2) ? (32'd1 << m_owner) : 32'd0;
        check("m_req_ready", req_ready, e_ready);
        check("m_rsp_valid", rsp_valid, e_valid);
        check("m_rsp_data",  rsp_data,  m_last_data);
        check("m_rsp_id",    rsp_id,    m_last_id);
        check("m_mul_a",     mul_a,     m_mul_a);
        check("m_mul_b",     mul_b,     m_mul_b);
        check("m_busy",      busy,      m_have);
        if (rst_n) begin
            if (!m_have) begin
                if (m_pick >= 0) begin
                    m_have  = 1; m_age = 1; m_owner = m_pick;
                    m_mul_a = req_a[32*m_pick +: 32];
                    m_mul_b = req_b[32*m_pick +: 32];
                end
            end else if (m_age == 1) begin
                m_age       = 2;
                m_last_data = fmul(m_mul_a, m_mul_b);
                m_last_id   = m_owner;
            end else if (rsp_ready[m_owner]) begin
                m_have = 0;
                m_ptr  = (m_owner + 1) % NREQ;
            end
        end
    end

    // One transaction on requester idx with rsp_ready held low for 'hold' response cycles.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] exp);
        int n;
        @(posedge clk); #1;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_valid[idx] = 1'b1;
        rsp_ready = (hold == 0) ? '1 : '0;
        n = 0;
        @(negedge clk);
        while (!req_ready[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("op_grant", req_ready, 32'd1 << idx);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
        check("op_exec_busy",  busy, 1);
        check("op_exec_valid", rsp_valid, 0);
        @(negedge clk);
        check("op_rsp_valid", rsp_valid, 32'd1 << idx);
        check("op_rsp_data",  rsp_data, exp);
        check("op_rsp_id",    rsp_id, idx);
        check("op_rsp_busy",  busy, 1);
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", rsp_valid, 32'd1 << idx);
                check("hold_data",  rsp_data, exp);
                check("hold_id",    rsp_id, idx);
            end
            @(posedge clk); #1;
            rsp_ready = '1;
            @(negedge clk);
            check("release_valid", rsp_valid, 32'd1 << idx);
        end
        @(negedge clk);
        check("op_done_busy",  busy, 0);
        check("op_done_valid", rsp_valid, 0);
    endtask

    task automatic collect(input int n, input int budget);
        int c;
        grants.delete();
        c = 0;
        while (grants.size() < n && c < budget) begin
            @(negedge clk);
            c++;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
        end
        check("grant_count", grants.size(), n);
    endtask

    initial begin
        int exp_order[5];
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy",  busy, 0);
        check("reset_data",  rsp_data, 0);
        check("reset_mul_a", mul_a, 0);

        // Single op, 2.0 * 3.0
        do_op(0, 32'h4000_0000, 32'h4040_0000, 0, 32'h40C0_0000);
        // Backpressure, 1.5 * 1.5, ready low for 5 cycles
        do_op(2, 32'h3FC0_0000, 32'h3FC0_0000, 5, 32'h4010_0000);
        // Sign and zero passthrough
        do_op(0, 32'hC000_0000, 32'h3F00_0000, 0, 32'hBF80_0000);
        do_op(3, 32'h0000_0000, 32'h4040_0000, 0, 32'h0000_0000);

        // Requesters 1 and 3 after serving 1: pointer at 2 gives 3, then 1
        do_op(1, 32'h4080_0000, 32'h3F80_0000, 0, 32'h4080_0000);
        @(posedge clk); #1;
        req_a[32*3 +: 32] = 32'h4100_0000; req_b[32*3 +: 32] = 32'h4000_0000;
        req_valid = 4'b1010;
        rsp_ready = '1;
        collect(2, 30);
        if (grants.size() > 0) check("rr_first", grants[0], 3);
        if (grants.size() > 1) check("rr_second", grants[1], 1);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // All four valid from reset
        #1 rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'h3F80_0000 + (i << 23);
            req_b[32*i +: 32] = 32'h4000_0000 + (i << 22);
        end
        req_valid = '1;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        collect(5, 40);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            if (k < grants.size()) check("all_order", grants[k], exp_order[k]);
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Reset during RESP for requester 1
        #1;
        req_a[32*1 +: 32] = 32'h4040_0000; req_b[32*1 +: 32] = 32'h4040_0000;
        req_valid = 4'b0010;
        rsp_ready = '0;
        @(negedge clk);
        check("rst_grant", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_valid", rsp_valid, 4'b0010);
        check("rst_pre_data",  rsp_data, 32'h4110_0000);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_data",  rsp_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        rsp_ready = '1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", rsp_valid, 0);
        end
        @(posedge clk); #1;
        req_a[32*3 +: 32] = 32'h4000_0000; req_b[32*3 +: 32] = 32'h4000_0000;
        req_valid = 4'b1010;
        collect(1, 20);
        if (grants.size() > 0) check("post_rst_grant", grants[0], 1);
        @(posedge clk); #1 req_valid = '0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpmul_arb.md
Name: fpmul_arb

Overview:
Round-robin arbiter and sequencer that shares one combinational single-precision FP multiplier (fpmul) among NREQ requesters.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Registers the operands onto the shared multiplier and captures the product.
- Returns the product to the owning requester over a valid/ready response channel.
- Sits between FP-issuing units (FPU lanes, vector helpers) and the single fpmul instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must equal clog2(NREQ)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  32*NREQ  operand A, requester i at bits [32i+31:32i]
req_b  in  32*NREQ  operand B, same packing
rsp_valid  out  NREQ  per-requester result valid; one-hot or zero
rsp_ready  in  NREQ  per-requester result accept
rsp_data  out  32  product, shared by all requesters
rsp_id  out  IDW  index of the requester owning rsp_data
mul_a  out  32  to fpmul input a
mul_b  out  32  to fpmul input b
mul_s  in  32  from fpmul output s
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0), all registers cleared immediately:
  - state=IDLE, rr_ptr=0, op_a=op_b=0, res=0, owner=0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, mul_a=mul_b=0, busy=0.
- State IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[grant]=1, combinational from req_valid and rr_ptr; all other bits 0.
  - If any req_valid is set, handshake completes that cycle: latch op_a/op_b from the granted slice, owner=grant, go to EXEC.
  - No req_valid: stay in IDLE, req_ready=0.
- State EXEC (1 cycle):
  - mul_a=op_a, mul_b=op_b; res <= mul_s at the clock edge.
  - Go to RESP.
- State RESP:
  - rsp_valid[owner]=1, rsp_data=res, rsp_id=owner.
  - Hold all three stable until rsp_ready[owner]=1.
  - On accept: rr_ptr <= (owner+1) mod NREQ, go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- mul_a/mul_b are driven from op_a/op_b in every state; they are registered and never combinational from req_a/req_b.
- rsp_data and rsp_id hold the last value outside RESP; rsp_valid is 0 outside RESP.
- Latency: handshake in cycle T gives rsp_valid in cycle T+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with immediate rsp_ready). No overlap between transactions.
- Requesters may drop req_valid before their handshake with no side effect; operands need not stay stable after it.
- Fairness: a continuously requesting requester is granted within NREQ transactions.
- No numerical handling in this block. Zero, overflow and sign results are whatever fpmul returns, passed through bit-exact.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded and no response is issued after reset.

Test Plan:
- Single op, req 0: a=0x40000000, b=0x40400000, rsp_ready=1 -> rsp_valid[0] two cycles after accept, rsp_data=0x40C00000, rsp_id=0, busy high for 2 cycles.
- Backpressure, req 2: 0x3FC00000*0x3FC00000 with rsp_ready low for 5 cycles -> rsp_valid[2] and rsp_data=0x40100000 held stable all 5 cycles; release completes the transaction, back to IDLE.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; no req_ready in non-IDLE cycles; each result matches its own operands.
- Sign/zero passthrough: 0xC0000000*0x3F000000 -> 0xBF800000; 0x00000000*0x40400000 -> 0x00000000.
- Req 1 and 3 valid, rr_ptr=2 after serving 1 -> next grant is 3, then 1.
- rst_n pulsed low during RESP for req 1 -> rsp_valid=0 immediately; no response after release; next request served normally from rr_ptr=0.
